mod_tx_scheduler: RTL and testbench

Transmit sequencer for the digital modulation chain. It accepts a frame of bytes over a valid/ready handshake and serializes them MSB-first into the 8-entry bit FIFO. It enables FIFO reads and the waveform generator once a prefill threshold is reached. It counts completed symbols via the generator's done pulse and signals end of frame, so software sees a byte-oriented, frame-level interface to the bit-level modulator.

---
 rtl/mod_tx_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_mod_tx_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_tx_scheduler.sv
// ---------------------------------------------------------------------------
// mod_tx_scheduler
//
// Transmit sequencer for the digital modulation chain. It takes a frame of
// bytes over a valid/ready handshake and serializes each byte MSB-first into
// the bit FIFO. Once enough bits are queued it enables FIFO reads and the
// waveform generator. It then counts completed symbols (send_in pulses) until
// the whole frame has gone out, and pulses frame_done.
//
// State table:
//   IDLE   | waiting for start with a non-zero frame_len
//   FILL   | serializing bytes into the FIFO, reads not yet enabled
//   STREAM | FIFO reads / generator enabled, counting symbols
//   DONE   | one-cycle frame_done pulse, then back to IDLE
//
// Ports:
//   CLK          clock, all state changes on posedge
//   RESET        synchronous, active-low reset
//   start        begin a frame (sampled in IDLE only)
//   frame_len    frame length in bytes, latched on an accepted start
//   byte_in      data byte
//   byte_valid   byte_in is valid
//   byte_ready   scheduler can take a byte this cycle
//   fifo_wEN     FIFO write enable
//   fifo_dIn     FIFO write bit
//   fifo_bFull   FIFO full
//   fifo_bEmpty  FIFO empty
//   fifo_rEN     FIFO read / generator enable
//   send_in      one-cycle pulse per completed symbol
//   busy         frame in progress
//   frame_done   one-cycle pulse at frame completion
//   underrun     sticky: FIFO ran empty while frame bits were still pending
// ---------------------------------------------------------------------------
module mod_tx_scheduler #(
    parameter int BYTE_W  = 8,
    parameter int LEN_W   = 8,
    parameter int PREFILL = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              fifo_wEN,
    output logic              fifo_dIn,
    input  logic              fifo_bFull,
    input  logic              fifo_bEmpty,
    output logic              fifo_rEN,
    input  logic              send_in,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    // Bit counters are wide enough for frame_len*BYTE_W, so they never wrap.
    localparam int TB_W  = LEN_W + $clog2(BYTE_W);
    localparam int CNT_W = $clog2(BYTE_W + 1);

    localparam logic [TB_W-1:0]  PREFILL_BITS = TB_W'(PREFILL);
    localparam logic [TB_W-1:0]  BYTE_BITS_TB = TB_W'(BYTE_W);
    localparam logic [CNT_W-1:0] BYTE_BITS    = CNT_W'(BYTE_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LEN_W-1:0]  len_q;
    logic [TB_W-1:0]   total_bits_q;
    logic [LEN_W-1:0]  bytes_taken_q;
    logic [TB_W-1:0]   bits_written_q;
    logic [TB_W-1:0]   symbols_sent_q;
    logic [BYTE_W-1:0] sh_q;
    logic [CNT_W-1:0]  sh_cnt_q;
    logic              underrun_q;

    logic              active;
    logic              accept_start;
    logic              load;
    logic [TB_W-1:0]   bits_written_inc;
    logic [TB_W-1:0]   symbols_sent_inc;
    logic              fill_met;

    // -----------------------------------------------------------------------
    // Datapath decode
    // -----------------------------------------------------------------------
    always_comb begin
        active           = (state_q == S_FILL) || (state_q == S_STREAM);
        accept_start     = (state_q == S_IDLE) && start && (frame_len != '0);
        byte_ready       = active && (sh_cnt_q == '0) && (bytes_taken_q < len_q);
        load             = byte_ready && byte_valid;
        // Writes are gated by fifo_bFull combinationally, so a full FIFO is
        // never written even if it fills on the previous edge.
        fifo_wEN         = active && (sh_cnt_q != '0) && !fifo_bFull;
        fifo_dIn         = sh_q[BYTE_W-1];
        bits_written_inc = bits_written_q + TB_W'(1);
        symbols_sent_inc = symbols_sent_q + TB_W'(1);
        // Evaluated on the post-write count so fifo_rEN rises in the cycle
        // right after the write that reaches the threshold.
        fill_met         = fifo_wEN &&
                           ((bits_written_inc >= PREFILL_BITS) ||
                            (bits_written_inc == total_bits_q));
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fifo_rEN   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (accept_start) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_met) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                fifo_rEN = 1'b1;
                if (send_in && (symbols_sent_inc == total_bits_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame setup, serializer and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            len_q          <= '0;
            total_bits_q   <= '0;
            bytes_taken_q  <= '0;
            bits_written_q <= '0;
            symbols_sent_q <= '0;
            sh_q           <= '0;
            sh_cnt_q       <= '0;
            underrun_q     <= 1'b0;
        end else if (accept_start) begin
            len_q          <= frame_len;
            total_bits_q   <= TB_W'(frame_len) * BYTE_BITS_TB;
            bytes_taken_q  <= '0;
            bits_written_q <= '0;
            symbols_sent_q <= '0;
            sh_q           <= '0;
            sh_cnt_q       <= '0;
            underrun_q     <= 1'b0;
        end else begin
            // A load needs an empty shifter and a write needs a non-empty
            // one, so the two branches are mutually exclusive.
            if (load) begin
                sh_q          <= byte_in;
                sh_cnt_q      <= BYTE_BITS;
                bytes_taken_q <= bytes_taken_q + LEN_W'(1);
            end else if (fifo_wEN) begin
                sh_q           <= sh_q << 1;
                sh_cnt_q       <= sh_cnt_q - CNT_W'(1);
                bits_written_q <= bits_written_inc;
            end

            if ((state_q == S_STREAM) && send_in) begin
                symbols_sent_q <= symbols_sent_inc;
            end

            // Empty FIFO with bits still to come means the generator starved;
            // flag it but keep the frame running.
            if ((state_q == S_STREAM) && fifo_bEmpty &&
                (bits_written_q < total_bits_q)) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign underrun = underrun_q;

endmodule

// File: tb/tb_mod_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mod_tx_scheduler
//
// Bench for mod_tx_scheduler. Two instances (PREFILL=4 and PREFILL=8) share
// all inputs; use8 selects which one drives the FIFO / generator model.
// The model is an 8-entry bit queue plus a generator that pops one bit every
// sym_time cycles while reads are enabled and the queue is non-empty.
// Expected bits are derived from the bytes handed over (MSB first).
// ---------------------------------------------------------------------------
module tb_mod_tx_scheduler;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 8;
    localparam int FIFO_D = 8;

    logic              CLK;
    logic              RESET;
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              fifo_bFull;
    logic              fifo_bEmpty;
    logic              send_in;

    logic rdy4, wen4, din4, ren4, busy4, done4, ur4;
    logic rdy8, wen8, din8, ren8, busy8, done8, ur8;

    logic use8;
    logic o_rdy, o_wen, o_din, o_ren, o_busy, o_done, o_ur;

    assign o_rdy  = use8 ? rdy8  : rdy4;
    assign o_wen  = use8 ? wen8  : wen4;
    assign o_din  = use8 ? din8  : din4;
    assign o_ren  = use8 ? ren8  : ren4;
    assign o_busy = use8 ? busy8 : busy4;
    assign o_done = use8 ? done8 : done4;
    assign o_ur   = use8 ? ur8   : ur4;

    mod_tx_scheduler #(.BYTE_W(BYTE_W), .LEN_W(LEN_W), .PREFILL(4)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .frame_len(frame_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy4),
        .fifo_wEN(wen4), .fifo_dIn(din4), .fifo_bFull(fifo_bFull),
        .fifo_bEmpty(fifo_bEmpty), .fifo_rEN(ren4), .send_in(send_in),
        .busy(busy4), .frame_done(done4), .underrun(ur4)
    );

    mod_tx_scheduler #(.BYTE_W(BYTE_W), .LEN_W(LEN_W), .PREFILL(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .start(start), .frame_len(frame_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy8),
        .fifo_wEN(wen8), .fifo_dIn(din8), .fifo_bFull(fifo_bFull),
        .fifo_bEmpty(fifo_bEmpty), .fifo_rEN(ren8), .send_in(send_in),
        .busy(busy8), .frame_done(done8), .underrun(ur8)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors;
    int checks;
    int cyc;

    bit          fq[$];
    bit          exp_bits[$];
    logic [7:0]  byte_src[$];
    bit          feed_en;
    int          sym_time;
    int          gen_cnt;
    bit          prev_ren;

    int n_wr, n_sym, n_done, n_fullwr, n_full, n_bitbad, n_done_ren;
    int ren_wr_at_rise;
    int start_cyc, first_rdy_cyc, first_acc_cyc, first_wen_cyc;
    int last_send_cyc, done_cyc;
    logic [31:0] wr_log;

    // One clock cycle: drive inputs after the falling edge, sample, let the
    // rising edge happen, then update the FIFO/generator model.
    task automatic step();
        bit s_wen, s_din, s_ren, s_rdy, s_done, s_acc;
        logic [7:0] b;
        byte_valid  = feed_en && (byte_src.size() > 0);
        byte_in     = byte_valid ? byte_src[0] : 8'h00;
        fifo_bFull  = (fq.size() >= FIFO_D);
        fifo_bEmpty = (fq.size() == 0);
        #1;
        s_wen  = o_wen;
        s_din  = o_din;
        s_ren  = o_ren;
        s_rdy  = o_rdy;
        s_done = o_done;
        s_acc  = byte_valid && s_rdy;
        send_in = 1'b0;
        if (s_ren && fq.size() > 0) begin
            if (gen_cnt >= sym_time - 1) begin
                send_in = 1'b1;
                gen_cnt = 0;
            end else begin
                gen_cnt++;
            end
        end else if (!s_ren) begin
            gen_cnt = 0;
        end
        if (s_wen && fifo_bFull) n_fullwr++;
        if (fifo_bFull) n_full++;
        if (s_rdy && first_rdy_cyc < 0) first_rdy_cyc = cyc;
        if (s_wen && first_wen_cyc < 0) first_wen_cyc = cyc;
        if (s_ren && !prev_ren && ren_wr_at_rise < 0) ren_wr_at_rise = n_wr;
        if (s_done) begin
            n_done++;
            done_cyc = cyc;
            if (s_ren) n_done_ren++;
        end
        #1;
        @(posedge CLK);
        if (!RESET) begin
            fq.delete();
            exp_bits.delete();
            gen_cnt = 0;
        end else begin
            if (s_wen) begin
                fq.push_back(s_din);
                n_wr++;
                wr_log = {wr_log[30:0], s_din};
                if (exp_bits.size() == 0) begin
                    n_bitbad++;
                end else begin
                    if (exp_bits[0] != s_din) n_bitbad++;
                    void'(exp_bits.pop_front());
                end
            end
            if (send_in) begin
                void'(fq.pop_front());
                n_sym++;
                last_send_cyc = cyc;
            end
            if (s_acc) begin
                b = byte_src.pop_front();
                for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
        end
        prev_ren = s_ren;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic clear_stats();
        n_wr = 0; n_sym = 0; n_done = 0; n_fullwr = 0; n_full = 0;
        n_bitbad = 0; n_done_ren = 0; ren_wr_at_rise = -1;
        first_rdy_cyc = -1; first_acc_cyc = -1; first_wen_cyc = -1;
        last_send_cyc = -1; done_cyc = -1; wr_log = '0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) byte_src.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic begin_frame(input int len, input int sym);
        clear_stats();
        exp_bits.delete();
        sym_time  = sym;
        feed_en   = 1'b1;
        frame_len = LEN_W'(len);
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic finish_frame(input int budget, output bit timed_out);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        timed_out = (n_done == 0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) step();
        RESET = 1'b1;
        step();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        RESET = 1'b0;
        start = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_busy, o_rdy, o_wen, o_din, o_ren, o_done, o_ur} !== 7'b0)
            begin errors++; $display("FAIL reset_outputs got=%b want=0000000",
                  {o_busy, o_rdy, o_wen, o_din, o_ren, o_done, o_ur}); end
        RESET = 1'b1;
        step();
        checks++;
        if ({o_busy, o_ren, o_done} !== 3'b0)
            begin errors++; $display("FAIL reset_idle got=%b want=000", {o_busy, o_ren, o_done}); end
    endtask

    task automatic test_a5();
        bit to;
        byte_src.delete();
        byte_src.push_back(8'hA5);
        begin_frame(1, 3);
        finish_frame(300, to);
        checks++;
        if (to) begin errors++; $display("FAIL a5_timeout got=no_done want=done"); end
        checks++;
        if (first_rdy_cyc - start_cyc !== 1)
            begin errors++; $display("FAIL a5_start_to_ready got=%0d want=1", first_rdy_cyc - start_cyc); end
        checks++;
        if (first_wen_cyc - first_acc_cyc !== 1)
            begin errors++; $display("FAIL a5_accept_to_wen got=%0d want=1", first_wen_cyc - first_acc_cyc); end
        checks++;
        if (wr_log[7:0] !== 8'hA5 || n_wr !== 8)
            begin errors++; $display("FAIL a5_bits got=%h/%0d want=a5/8", wr_log[7:0], n_wr); end
        checks++;
        if (ren_wr_at_rise !== 4)
            begin errors++; $display("FAIL a5_ren_rise got=%0d want=4", ren_wr_at_rise); end
        checks++;
        if (n_sym !== 8 || n_done !== 1)
            begin errors++; $display("FAIL a5_counts got=sym%0d/done%0d want=8/1", n_sym, n_done); end
        checks++;
        if (done_cyc !== last_send_cyc + 1 || n_done_ren !== 0)
            begin errors++; $display("FAIL a5_done_timing got=%0d/%0d want=%0d/0",
                  done_cyc, n_done_ren, last_send_cyc + 1); end
        step();
        checks++;
        if (o_busy !== 1'b0 || o_ur !== 1'b0)
            begin errors++; $display("FAIL a5_idle got=busy%b/ur%b want=0/0", o_busy, o_ur); end
    endtask

    task automatic test_back_to_back();
        bit to;
        byte_src.delete();
        fill_random(3);
        begin_frame(3, 6);
        finish_frame(400, to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout got=no_done want=done"); end
        checks++;
        if (n_fullwr !== 0)
            begin errors++; $display("FAIL b2b_write_when_full got=%0d want=0", n_fullwr); end
        checks++;
        if (n_full == 0)
            begin errors++; $display("FAIL b2b_fifo_filled got=%0d want=>0", n_full); end
        checks++;
        if (n_wr !== 24 || n_sym !== 24 || n_done !== 1 || n_bitbad !== 0)
            begin errors++; $display("FAIL b2b_counts got=%0d/%0d/%0d/%0d want=24/24/1/0",
                  n_wr, n_sym, n_done, n_bitbad); end
        checks++;
        if (o_ur !== 1'b0)
            begin errors++; $display("FAIL b2b_underrun got=%b want=0", o_ur); end
    endtask

    task automatic test_underrun();
        bit to;
        byte_src.delete();
        fill_random(1);
        begin_frame(2, 1);
        repeat (40) step();
        checks++;
        if (o_ur !== 1'b1 || n_sym !== 8)
            begin errors++; $display("FAIL ur_set got=ur%b/sym%0d want=1/8", o_ur, n_sym); end
        fill_random(1);
        finish_frame(200, to);
        checks++;
        if (to || n_sym !== 16 || n_done !== 1 || n_bitbad !== 0)
            begin errors++; $display("FAIL ur_complete got=to%0d/sym%0d/done%0d/bad%0d want=0/16/1/0",
                  to, n_sym, n_done, n_bitbad); end
        checks++;
        if (o_ur !== 1'b1)
            begin errors++; $display("FAIL ur_sticky got=%b want=1", o_ur); end
        step();
        fill_random(1);
        begin_frame(1, 2);
        checks++;
        if (o_ur !== 1'b0)
            begin errors++; $display("FAIL ur_cleared_by_start got=%b want=0", o_ur); end
        finish_frame(200, to);
        checks++;
        if (to || n_sym !== 8 || o_ur !== 1'b0)
            begin errors++; $display("FAIL ur_next_frame got=to%0d/sym%0d/ur%b want=0/8/0", to, n_sym, o_ur); end
    endtask

    task automatic test_ignored_start();
        bit to;
        step();
        n_done = 0;
        byte_src.delete();
        frame_len = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++;
        if (o_busy !== 1'b0 || n_done !== 0)
            begin errors++; $display("FAIL zero_len_start got=busy%b/done%0d want=0/0", o_busy, n_done); end
        fill_random(2);
        begin_frame(2, 3);
        repeat (10) step();
        frame_len = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        frame_len = 8'd2;
        checks++;
        if (o_busy !== 1'b1)
            begin errors++; $display("FAIL busy_start_busy got=%b want=1", o_busy); end
        finish_frame(300, to);
        repeat (5) step();
        checks++;
        if (to || n_sym !== 16 || n_done !== 1 || n_wr !== 16)
            begin errors++; $display("FAIL busy_start_ignored got=to%0d/sym%0d/done%0d/wr%0d want=0/16/1/16",
                  to, n_sym, n_done, n_wr); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int k;
        byte_src.delete();
        fill_random(3);
        begin_frame(3, 4);
        k = 0;
        while (!o_ren && k < 100) begin step(); k++; end
        checks++;
        if (o_ren !== 1'b1)
            begin errors++; $display("FAIL rmid_reach_stream got=%b want=1", o_ren); end
        repeat (3) step();
        RESET = 1'b0;
        byte_src.delete();
        step();
        RESET = 1'b1;
        checks++;
        if ({o_busy, o_rdy, o_wen, o_din, o_ren, o_done, o_ur} !== 7'b0)
            begin errors++; $display("FAIL rmid_outputs got=%b want=0000000",
                  {o_busy, o_rdy, o_wen, o_din, o_ren, o_done, o_ur}); end
        step();
        fill_random(1);
        begin_frame(1, 2);
        finish_frame(200, to);
        checks++;
        if (to || n_wr !== 8 || n_sym !== 8 || n_done !== 1 || n_bitbad !== 0 || ren_wr_at_rise !== 4)
            begin errors++; $display("FAIL rmid_fresh_frame got=to%0d/wr%0d/sym%0d/done%0d/bad%0d/rise%0d want=0/8/8/1/0/4",
                  to, n_wr, n_sym, n_done, n_bitbad, ren_wr_at_rise); end
    endtask

    task automatic test_random();
        bit to;
        int len, sym;
        for (int f = 0; f < 6; f++) begin
            step();
            len = $urandom_range(1, 4);
            sym = $urandom_range(2, 5);
            byte_src.delete();
            fill_random(len);
            begin_frame(len, sym);
            finish_frame(len * 8 * sym + 100, to);
            checks++;
            if (to || n_wr !== len * 8 || n_sym !== len * 8 || n_done !== 1)
                begin errors++; $display("FAIL rand_counts f=%0d got=to%0d/wr%0d/sym%0d/done%0d want=0/%0d/%0d/1",
                      f, to, n_wr, n_sym, n_done, len * 8, len * 8); end
            checks++;
            if (n_bitbad !== 0 || n_fullwr !== 0 || o_ur !== 1'b0 || ren_wr_at_rise !== 4)
                begin errors++; $display("FAIL rand_data f=%0d got=bad%0d/fullwr%0d/ur%b/rise%0d want=0/0/0/4",
                      f, n_bitbad, n_fullwr, o_ur, ren_wr_at_rise); end
        end
    endtask

    task automatic test_prefill8();
        bit to;
        use8 = 1'b1;
        byte_src.delete();
        do_reset();
        fill_random(1);
        begin_frame(1, 2);
        finish_frame(200, to);
        checks++;
        if (ren_wr_at_rise !== 8)
            begin errors++; $display("FAIL p8_ren_rise got=%0d want=8", ren_wr_at_rise); end
        checks++;
        if (to || n_sym !== 8 || n_done !== 1 || n_bitbad !== 0 || done_cyc !== last_send_cyc + 1)
            begin errors++; $display("FAIL p8_complete got=to%0d/sym%0d/done%0d/bad%0d want=0/8/1/0",
                  to, n_sym, n_done, n_bitbad); end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        RESET = 1'b0; start = 1'b0; frame_len = '0; byte_in = '0;
        byte_valid = 1'b0; fifo_bFull = 1'b0; fifo_bEmpty = 1'b1; send_in = 1'b0;
        use8 = 1'b0; feed_en = 1'b0; sym_time = 1; gen_cnt = 0; prev_ren = 1'b0;
        clear_stats();
        @(negedge CLK);
        test_reset();
        test_a5();
        test_back_to_back();
        test_underrun();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_prefill8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
